// File: rtl/bus_transfer_sequencer.sv
// Register-transfer sequencer: turns MOVE / LOADI / SWAP requests into registered enable strobes
// for a negedge-capturing word-register bank sharing one tri-state bus, plus the immediate driver.
module bus_transfer_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int WIDTH    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [1:0]          i_req_op,
    input  logic [ADDR_W-1:0]   i_req_src,
    input  logic [ADDR_W-1:0]   i_req_dst,
    input  logic [WIDTH-1:0]    i_req_imm,
    output logic [NUM_REGS-1:0] o_enable_out,
    output logic [NUM_REGS-1:0] o_enable_in,
    output logic                o_temp_out,
    output logic                o_temp_in,
    output logic [WIDTH-1:0]    o_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_LOADI, S_SWAP1, S_SWAP2, S_SWAP3
    } state_t;

    localparam logic [1:0]      OP_MOVE     = 2'b00;
    localparam logic [1:0]      OP_LOADI    = 2'b01;
    localparam logic [1:0]      OP_SWAP     = 2'b10;
    localparam logic [1:0]      OP_RSVD     = 2'b11;
    localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    state_t                r_state;
    logic [ADDR_W-1:0]     r_src;
    logic [ADDR_W-1:0]     r_dst;
    logic [WIDTH-1:0]      r_imm;
    logic [NUM_REGS-1:0]   r_enable_out;
    logic [NUM_REGS-1:0]   r_enable_in;
    logic                  r_temp_out;
    logic                  r_temp_in;
    logic                  r_bus_drive;
    logic                  r_done;
    logic                  r_err;

    logic [NUM_REGS-1:0]   w_req_src_oh;
    logic [NUM_REGS-1:0]   w_req_dst_oh;
    logic [NUM_REGS-1:0]   w_src_oh;
    logic [NUM_REGS-1:0]   w_dst_oh;
    logic                  w_src_bad;
    logic                  w_dst_bad;
    logic                  w_invalid;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign w_req_src_oh[gi] = (i_req_src == ADDR_W'(gi));
        assign w_req_dst_oh[gi] = (i_req_dst == ADDR_W'(gi));
        assign w_src_oh[gi]     = (r_src == ADDR_W'(gi));
        assign w_dst_oh[gi]     = (r_dst == ADDR_W'(gi));
    end

    // LOADI never reads a register, so its src field is not range-checked
    assign w_src_bad = ({1'b0, i_req_src} >= LP_NUM_REGS) && (i_req_op != OP_LOADI);
    assign w_dst_bad = ({1'b0, i_req_dst} >= LP_NUM_REGS);
    assign w_invalid = (i_req_op == OP_RSVD) || w_src_bad || w_dst_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_imm        <= '0;
            r_enable_out <= '0;
            r_enable_in  <= '0;
            r_temp_out   <= 1'b0;
            r_temp_in    <= 1'b0;
            r_bus_drive  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_enable_out <= '0;
            r_enable_in  <= '0;
            r_temp_out   <= 1'b0;
            r_temp_in    <= 1'b0;
            r_bus_drive  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && w_invalid) begin
                        r_err <= 1'b1;
                    end else if (i_req_valid) begin
                        r_src <= i_req_src;
                        r_dst <= i_req_dst;
                        r_imm <= i_req_imm;
                        // strobes for the first phase are loaded on the accept edge
                        if (i_req_op == OP_LOADI) begin
                            r_state     <= S_LOADI;
                            r_bus_drive <= 1'b1;
                            r_enable_in <= w_req_dst_oh;
                            r_done      <= 1'b1;
                        end else if (i_req_op == OP_SWAP && i_req_src != i_req_dst) begin
                            r_state      <= S_SWAP1;
                            r_enable_out <= w_req_src_oh;
                            r_temp_in    <= 1'b1;
                        end else begin
                            r_state      <= S_MOVE;
                            r_enable_out <= w_req_src_oh;
                            r_enable_in  <= w_req_dst_oh;
                            r_done       <= 1'b1;
                        end
                    end
                end
                S_SWAP1: begin
                    r_state      <= S_SWAP2;
                    r_enable_out <= w_dst_oh;
                    r_enable_in  <= w_src_oh;
                end
                S_SWAP2: begin
                    r_state     <= S_SWAP3;
                    r_temp_out  <= 1'b1;
                    r_enable_in <= w_dst_oh;
                    r_done      <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_enable_out = r_enable_out;
    assign o_enable_in  = r_enable_in;
    assign o_temp_out   = r_temp_out;
    assign o_temp_in    = r_temp_in;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_bus        = r_bus_drive ? r_imm : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer (6 registers, so out-of-range indices are reachable) with a
// negedge register bank on the bus and a request-level model of register contents.
module tb_bus_transfer_sequencer;

    localparam int NR = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic [1:0]    req_op = 2'b00;
    logic [2:0]    req_src = 3'd0;
    logic [2:0]    req_dst = 3'd0;
    logic [31:0]   req_imm = 32'd0;
    logic          req_ready;
    logic [NR-1:0] en_out;
    logic [NR-1:0] en_in;
    logic          temp_out;
    logic          temp_in;
    wire  [31:0]   bus;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] bank [NR];
    logic [31:0] temp_q;
    logic [31:0] ref_regs [NR];
    logic [31:0] bus_data;
    logic        bank_clr = 1'b1;

    bus_transfer_sequencer #(.NUM_REGS(NR), .ADDR_W(3), .WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_src    (req_src),
        .i_req_dst    (req_dst),
        .i_req_imm    (req_imm),
        .o_enable_out (en_out),
        .o_enable_in  (en_in),
        .o_temp_out   (temp_out),
        .o_temp_in    (temp_in),
        .o_bus        (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    // Word-register bank and temp register: capture on the falling edge from whoever drives the bus
    always_comb begin
        bus_data = bus;
        if (temp_out) bus_data = temp_q;
        for (int i = 0; i < NR; i++) if (en_out[i]) bus_data = bank[i];
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bank_clr)     bank[i] <= 32'd0;
            else if (en_in[i]) bank[i] <= bus_data;
        end
        if (bank_clr)     temp_q <= 32'd0;
        else if (temp_in) temp_q <= bus_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs();
        for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), bank[i], ref_regs[i]);
    endtask

    // Issue one request at posedge+1 with the sequencer idle; check every cycle until idle again.
    task automatic run_req(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [31:0] imm);
        logic [NR-1:0] e_out [3];
        logic [NR-1:0] e_in  [3];
        logic          e_tout[3];
        logic          e_tin [3];
        logic          e_drv [3];
        logic          e_done[3];
        logic          bad;
        logic [31:0]   t;
        int            n;
        int            drivers;
        int            sinks;

        bad = (op == 2'b11) || (dst >= 3'(NR)) || (op != 2'b01 && src >= 3'(NR));
        for (int c = 0; c < 3; c++) begin
            e_out[c] = '0; e_in[c] = '0; e_tout[c] = 0; e_tin[c] = 0; e_drv[c] = 0; e_done[c] = 0;
        end
        n = 1;
        if (!bad) begin
            if (op == 2'b01) begin
                e_drv[0] = 1; e_in[0] = NR'(1) << dst; e_done[0] = 1;
            end else if (op == 2'b10 && src != dst) begin
                n = 3;
                e_out[0] = NR'(1) << src; e_tin[0] = 1;
                e_out[1] = NR'(1) << dst; e_in[1] = NR'(1) << src;
                e_tout[2] = 1;            e_in[2] = NR'(1) << dst; e_done[2] = 1;
            end else begin
                e_out[0] = NR'(1) << src; e_in[0] = NR'(1) << dst; e_done[0] = 1;
            end
        end

        $display("req op=%0d src=%0d dst=%0d imm=%08h expect_err=%0d cycles=%0d", op, src, dst, imm, bad, n);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_imm = imm;
        @(posedge clk); #1;

        for (int c = 0; c < n; c++) begin
            // junk on the request port while busy must be ignored
            if (c < n - 1) begin
                req_valid = 1'b1;
                req_op  = 2'($urandom_range(3));
                req_src = 3'($urandom_range(7));
                req_dst = 3'($urandom_range(7));
                req_imm = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            if (bad) begin
                chk("err_pulse", {31'd0, err}, 32'd1);
                chk("err_busy", {31'd0, busy}, 32'd0);
                chk("err_ready", {31'd0, req_ready}, 32'd1);
                chk("err_done", {31'd0, done}, 32'd0);
                chk("err_en_out", {26'd0, en_out}, 32'd0);
                chk("err_en_in", {26'd0, en_in}, 32'd0);
                chk("err_temp", {30'd0, temp_out, temp_in}, 32'd0);
            end else begin
                chk("busy", {31'd0, busy}, 32'd1);
                chk("ready_busy", {31'd0, req_ready}, 32'd0);
                chk("en_out", {26'd0, en_out}, {26'd0, e_out[c]});
                chk("en_in", {26'd0, en_in}, {26'd0, e_in[c]});
                chk("temp_out", {31'd0, temp_out}, {31'd0, e_tout[c]});
                chk("temp_in", {31'd0, temp_in}, {31'd0, e_tin[c]});
                chk("done", {31'd0, done}, {31'd0, e_done[c]});
                chk("err_quiet", {31'd0, err}, 32'd0);
                if (e_drv[c]) chk("bus_imm", bus, imm);
                else          chk("bus_released", {31'd0, bus !== imm}, 32'd1);
                drivers = $countones(en_out) + int'(temp_out) + int'(e_drv[c]);
                sinks   = $countones(en_in) + int'(temp_in);
                chk("one_driver", {31'd0, drivers <= 1}, 32'd1);
                chk("one_sink", {31'd0, sinks <= 1}, 32'd1);
            end
            @(posedge clk); #1;
        end

        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_strobes", {18'd0, en_out, en_in, temp_out, temp_in}, 32'd0);
        chk("idle_bus", {31'd0, bus !== imm}, 32'd1);

        if (!bad) begin
            case (op)
                2'b00: ref_regs[dst] = ref_regs[src];
                2'b01: ref_regs[dst] = imm;
                default: begin
                    t = ref_regs[src]; ref_regs[src] = ref_regs[dst]; ref_regs[dst] = t;
                end
            endcase
        end
        chk_regs();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) ref_regs[i] = 32'd0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_strobes", {18'd0, en_out, en_in, temp_out, temp_in}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(posedge clk); #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bank_clr = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        run_req(2'b01, 3'd0, 3'd1, 32'h0000_0011);
        run_req(2'b01, 3'd0, 3'd3, 32'h0000_0033);
        run_req(2'b01, 3'd7, 3'd2, 32'hA5A5_0002);
        run_req(2'b00, 3'd2, 3'd5, 32'h0000_0001);
        chk("move_r5", bank[5], 32'hA5A5_0002);
        run_req(2'b10, 3'd1, 3'd3, 32'h0000_0001);
        chk("swap_r1", bank[1], 32'h0000_0033);
        chk("swap_r3", bank[3], 32'h0000_0011);
        run_req(2'b01, 3'd0, 3'd4, 32'hDEAD_BEEF);
        run_req(2'b10, 3'd2, 3'd2, 32'h0000_0001);
        run_req(2'b00, 3'd4, 3'd4, 32'h0000_0001);
        run_req(2'b00, 3'd1, 3'd6, 32'h0000_0001);
        run_req(2'b01, 3'd0, 3'd7, 32'h1234_5679);
        run_req(2'b11, 3'd1, 3'd2, 32'h0000_0001);
        run_req(2'b10, 3'd6, 3'd0, 32'h0000_0001);
        run_req(2'b00, 3'd5, 3'd0, 32'h0000_0001);

        // reset asserted during SWAP2 clears strobes at once; registers keep their values
        $display("req op=2 src=0 dst=4 aborted by reset in phase 2");
        req_valid = 1'b1; req_op = 2'b10; req_src = 3'd0; req_dst = 3'd4; req_imm = 32'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_swap1_out", {26'd0, en_out}, 32'h01);
        @(posedge clk); #1;
        chk("abort_swap2_out", {26'd0, en_out}, 32'h10);
        chk("abort_swap2_in", {26'd0, en_in}, 32'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes", {18'd0, en_out, en_in, temp_out, temp_in}, 32'd0);
        chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_regs();

        for (int k = 0; k < 60; k++) begin
            run_req(2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                    $urandom | 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
